ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX boundary stage that directly feeds the CLA add/sub unit.
- Registers decoded operands behind a valid/ready handshake, using a 2-entry skid buffer so decode never sees a combinational ready path.
- Resolves RAW hazards by forwarding from MEM and WB, and keeps stalled entries fresh by snooping WB writes.
- Drives Rs1, Rs2, En and funct7_5 of the adder.

Parameters:
- WIDTH, 32, operand data width.
- REG_AW, 5, register-address width (x0 = address 0).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all held entries (branch redirect).
- in_valid  input  1  decode presents an entry.
- in_ready  output  1  stage can accept; registered.
- in_rs1_data  input  WIDTH  register-file read for rs1.
- in_rs2_data  input  WIDTH  register-file read for rs2.
- in_rs1_addr  input  REG_AW  source register 1 address.
- in_rs2_addr  input  REG_AW  source register 2 address.
- in_rd_addr  input  REG_AW  destination register address.
- in_alu_en  input  1  entry uses the adder.
- in_sub  input  1  subtract (funct7 bit 5).
- mem_wr  input  1  MEM stage will write rd.
- mem_rd  input  REG_AW  MEM destination.
- mem_data  input  WIDTH  MEM result.
- wb_wr  input  1  WB writes the register file this cycle.
- wb_rd  input  REG_AW  WB destination.
- wb_data  input  WIDTH  WB data.
- out_valid  output  1  head entry valid to EX.
- out_ready  input  1  EX consumes the head this cycle.
- Rs1  output  WIDTH  forwarded operand 1.
- Rs2  output  WIDTH  forwarded operand 2.
- En  output  1  out_valid & head alu_en.
- funct7_5  output  1  head sub bit when En, else 0.
- rd_addr  output  REG_AW  head destination.

Behaviour:
- Storage:
  - Head entry H and skid entry S.
  - Each entry holds valid, rs1/rs2 data and address, rd, alu_en, sub.
- Reset (rst_n low, asynchronous):
  - All valids 0, all fields 0, in_ready 1.
  - out_valid, En, funct7_5, Rs1, Rs2 and rd_addr all read 0.
- Occupancy states: EMPTY (no valid entry), ONE (H valid), FULL (H and S valid).
  - in_ready is 1 in EMPTY and ONE, 0 in FULL.
  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Transitions:
  - EMPTY + accept -> ONE (entry written to H).
  - ONE + accept, no pop -> FULL (entry written to S).
  - ONE + accept + pop -> ONE (new entry written to H).
  - ONE + pop, no accept -> EMPTY.
  - FULL + pop -> ONE (S moves to H, S cleared). Accept is impossible in FULL.
  - Order is preserved; latency from accept to out_valid is 1 cycle when empty.
- flush:
  - Overrides everything: next state EMPTY and in_ready 1.
  - An accept in the same cycle is discarded.
- WB snoop:
  - Every cycle, for each valid held entry, if wb_wr and wb_rd != 0 and wb_rd matches a source address, that source's stored data is replaced with wb_data.
  - An entry accepted in the same cycle as a matching WB write captures wb_data, not the register-file data.
- Output forwarding (combinational from H):
  - Per operand, priority: address 0 -> 0; else mem_wr & mem_rd match -> mem_data; else wb_wr & wb_rd match -> wb_data; else stored data.
  - Rs1 and Rs2 are forced to 0 when out_valid is 0.
- The adder's carry-in equals funct7_5, so funct7_5 must be 0 whenever En is 0.
- All arithmetic is pure selection; no widths change.

Test Plan:
- Reset mid-FULL: load two entries, hold out_ready=0, pulse rst_n low -> in_ready=1, out_valid=0, Rs1=Rs2=0 immediately (asynchronous).
- Back-to-back streaming:
  - Stimulus: in_valid=1 every cycle, out_ready=1, rs1_data 1,2,3,...
  - Required: out_valid from cycle 1, Rs1 sequence 1,2,3 with no bubbles, state stays ONE, in_ready constantly 1.
- Stall/skid:
  - Stimulus: out_ready=0 while two entries arrive (A: rs1=0x10, B: rs1=0x20).
  - Required: in_ready=0 after the second accept; releasing out_ready gives Rs1=0x10 then 0x20; nothing dropped or duplicated.
- Forward priority and x0:
  - Head rs1_addr=5, rs2_addr=0; mem_wr=1 mem_rd=5 mem_data=0xAAAA; wb_wr=1 wb_rd=5 wb_data=0xBBBB -> Rs1=0xAAAA, Rs2=0.
  - With mem_wr=0 -> Rs1=0xBBBB.
  - With in_sub=1, in_alu_en=1 -> En=1, funct7_5=1.
- Snoop while stalled:
  - Head rs2_addr=7 stored 0x1; out_ready=0; one-cycle wb_wr=1 wb_rd=7 wb_data=0x99; mem_wr=0.
  - Required: Rs2=0x99 after the pulse ends, retained until pop.
- Flush with accept:
  - Stimulus: FULL state, flush=1 together with in_valid=1.
  - Required: next cycle out_valid=0, in_ready=1, En=0, funct7_5=0; following entry accepted normally.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage feeding the CLA add/sub unit.
// Two-entry skid buffer (head H, skid S) behind a registered ready, so decode never sees a
// combinational ready path. Operands are forwarded from MEM/WB at the head. Held entries
// snoop WB writes so they stay correct while stalled.
module ex_operand_stage #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_rs1_data,
  input  logic [WIDTH-1:0]  in_rs2_data,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              in_alu_en,
  input  logic              in_sub,
  input  logic              mem_wr,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  Rs1,
  output logic [WIDTH-1:0]  Rs2,
  output logic              En,
  output logic              funct7_5,
  output logic [REG_AW-1:0] rd_addr
);

  typedef struct packed {
    logic              valid;
    logic [WIDTH-1:0]  rs1_data;
    logic [WIDTH-1:0]  rs2_data;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd;
    logic              alu_en;
    logic              sub;
  } entry_t;

  entry_t h_q, h_d, s_q, s_d;
  entry_t h_snp, s_snp, in_entry;
  logic   in_ready_q, in_ready_d;
  logic   accept, pop;

  // Replace a valid entry's source data with a WB write that targets it (x0 is never written).
  function automatic entry_t snoop(entry_t e, logic wr, logic [REG_AW-1:0] rd,
                                   logic [WIDTH-1:0] data);
    entry_t r;
    r = e;
    if (e.valid && wr && (rd != '0)) begin
      if (rd == e.rs1_addr) r.rs1_data = data;
      if (rd == e.rs2_addr) r.rs2_data = data;
    end
    return r;
  endfunction

  // Bypass priority: x0, then MEM (younger), then WB, then stored data.
  function automatic logic [WIDTH-1:0] fwd(logic [REG_AW-1:0] addr, logic [WIDTH-1:0] stored);
    logic [WIDTH-1:0] r;
    if (addr == '0)                    r = '0;
    else if (mem_wr && mem_rd == addr) r = mem_data;
    else if (wb_wr && wb_rd == addr)   r = wb_data;
    else                               r = stored;
    return r;
  endfunction

  assign accept = in_valid & in_ready_q;
  assign pop    = h_q.valid & out_ready;

  // Snooped views of held entries and the incoming entry (which captures a same-cycle WB write).
  always_comb begin
    h_snp             = snoop(h_q, wb_wr, wb_rd, wb_data);
    s_snp             = snoop(s_q, wb_wr, wb_rd, wb_data);
    in_entry          = '0;
    in_entry.valid    = 1'b1;
    in_entry.rs1_data = in_rs1_data;
    in_entry.rs2_data = in_rs2_data;
    in_entry.rs1_addr = in_rs1_addr;
    in_entry.rs2_addr = in_rs2_addr;
    in_entry.rd       = in_rd_addr;
    in_entry.alu_en   = in_alu_en;
    in_entry.sub      = in_sub;
    in_entry          = snoop(in_entry, wb_wr, wb_rd, wb_data);
  end

  // Occupancy transitions EMPTY/ONE/FULL, encoded by the two valid bits.
  always_comb begin
    h_d = h_snp;
    s_d = s_snp;
    if (flush) begin
      h_d = '0;
      s_d = '0;
    end else if (!h_q.valid) begin
      if (accept) h_d = in_entry;
    end else if (!s_q.valid) begin
      if (accept && pop)  h_d = in_entry;
      else if (accept)    s_d = in_entry;
      else if (pop)       h_d = '0;
    end else if (pop) begin
      h_d = s_snp;
      s_d = '0;
    end
    in_ready_d = ~(h_d.valid & s_d.valid);
  end

  // Entry registers and registered ready.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      h_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      h_q        <= h_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Head outputs; operands and carry-in are zero whenever nothing valid is presented.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = h_q.valid;
    En        = h_q.valid & h_q.alu_en;
    funct7_5  = En & h_q.sub;
    rd_addr   = h_q.rd;
    Rs1       = '0;
    Rs2       = '0;
    if (h_q.valid) begin
      Rs1 = fwd(h_q.rs1_addr, h_q.rs1_data);
      Rs2 = fwd(h_q.rs2_addr, h_q.rs2_data);
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage. Inputs change 1 time unit after the rising edge,
// outputs are sampled away from the edge.
module tb_ex_operand_stage;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned REG_AW = 5;

  logic              CLK = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_rs1_data, in_rs2_data;
  logic [REG_AW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic              in_alu_en, in_sub;
  logic              mem_wr;
  logic [REG_AW-1:0] mem_rd;
  logic [WIDTH-1:0]  mem_data;
  logic              wb_wr;
  logic [REG_AW-1:0] wb_rd;
  logic [WIDTH-1:0]  wb_data;
  logic              out_valid, out_ready;
  logic [WIDTH-1:0]  Rs1, Rs2;
  logic              En, funct7_5;
  logic [REG_AW-1:0] rd_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  ex_operand_stage #(.WIDTH(WIDTH), .REG_AW(REG_AW)) dut (
    .CLK(CLK), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_alu_en(in_alu_en), .in_sub(in_sub),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .Rs1(Rs1), .Rs2(Rs2), .En(En), .funct7_5(funct7_5), .rd_addr(rd_addr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [31:0] d1, input logic [31:0] d2,
                     input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                     input logic en, input logic sub);
    in_valid    = 1'b1;
    in_rs1_data = d1;
    in_rs2_data = d2;
    in_rs1_addr = a1;
    in_rs2_addr = a2;
    in_rd_addr  = rd;
    in_alu_en   = en;
    in_sub      = sub;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rs1_data = '0; in_rs2_data = '0; in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
    in_alu_en = 1'b0; in_sub = 1'b0;
    mem_wr = 1'b0; mem_rd = '0; mem_data = '0; wb_wr = 1'b0; wb_rd = '0; wb_data = '0;
    #12;
    check_eq("rst in_ready", in_ready, 1);
    check_eq("rst out_valid", out_valid, 0);
    check_eq("rst En", En, 0);
    check_eq("rst Rs1", Rs1, 0);
    rst_n = 1'b1;
    cyc();

    // Back-to-back streaming: one cycle latency, no bubbles.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      put(i, 32'h100 + i, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      cyc();
      check_eq($sformatf("stream out_valid %0d", i), out_valid, 1);
      check_eq($sformatf("stream Rs1 %0d", i), Rs1, i);
      check_eq($sformatf("stream in_ready %0d", i), in_ready, 1);
    end
    in_valid = 1'b0;
    cyc();
    check_eq("stream drained", out_valid, 0);

    // Stall and skid.
    out_ready = 1'b0;
    put(32'h10, 0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    cyc();
    check_eq("skid A Rs1", Rs1, 32'h10);
    check_eq("skid ONE ready", in_ready, 1);
    put(32'h20, 0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    cyc();
    in_valid = 1'b0;
    check_eq("skid FULL ready", in_ready, 0);
    check_eq("skid hold A", Rs1, 32'h10);
    out_ready = 1'b1;
    cyc();
    check_eq("skid B Rs1", Rs1, 32'h20);
    check_eq("skid ready back", in_ready, 1);
    cyc();
    check_eq("skid empty", out_valid, 0);
    out_ready = 1'b0;

    // Forward priority and x0.
    put(32'h1111, 32'h2222, 5'd5, 5'd0, 5'd3, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    mem_wr = 1'b1; mem_rd = 5'd5; mem_data = 32'hAAAA;
    wb_wr  = 1'b1; wb_rd  = 5'd5; wb_data  = 32'hBBBB;
    #1;
    check_eq("fwd mem Rs1", Rs1, 32'hAAAA);
    check_eq("fwd x0 Rs2", Rs2, 0);
    check_eq("fwd En", En, 1);
    check_eq("fwd funct7_5", funct7_5, 1);
    check_eq("fwd rd_addr", rd_addr, 3);
    mem_wr = 1'b0;
    #1;
    check_eq("fwd wb Rs1", Rs1, 32'hBBBB);
    wb_wr = 1'b0;
    #1;
    check_eq("fwd stored Rs1", Rs1, 32'h1111);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check_eq("fwd popped En", En, 0);

    // Snoop while stalled; alu_en=0 must mask the sub bit.
    put(32'h3, 32'h1, 5'd1, 5'd7, 5'd4, 1'b0, 1'b1);
    cyc();
    in_valid = 1'b0;
    check_eq("snoop pre Rs2", Rs2, 1);
    check_eq("snoop En off", En, 0);
    check_eq("snoop funct7_5 off", funct7_5, 0);
    wb_wr = 1'b1; wb_rd = 5'd7; wb_data = 32'h99;
    cyc();
    wb_wr = 1'b0;
    check_eq("snoop Rs2", Rs2, 32'h99);
    cyc();
    check_eq("snoop retained", Rs2, 32'h99);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check_eq("snoop popped", out_valid, 0);

    // Accept coincident with a matching WB write captures wb_data.
    put(32'h5, 32'h6, 5'd4, 5'd2, 5'd1, 1'b1, 1'b0);
    wb_wr = 1'b1; wb_rd = 5'd4; wb_data = 32'h77;
    cyc();
    in_valid = 1'b0; wb_wr = 1'b0;
    check_eq("capture Rs1", Rs1, 32'h77);
    check_eq("capture Rs2", Rs2, 32'h6);

    // Flush from ONE with a real accept: the accepted entry is discarded too.
    flush = 1'b1;
    put(32'h66, 0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush ONE out_valid", out_valid, 0);

    // Flush from FULL.
    put(32'h30, 0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    cyc();
    put(32'h40, 0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    cyc();
    check_eq("flush pre ready", in_ready, 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush out_valid", out_valid, 0);
    check_eq("flush in_ready", in_ready, 1);
    check_eq("flush En", En, 0);
    check_eq("flush funct7_5", funct7_5, 0);
    put(32'h50, 0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    cyc();
    in_valid = 1'b0;
    check_eq("post flush valid", out_valid, 1);
    check_eq("post flush Rs1", Rs1, 32'h50);

    // Asynchronous reset mid-FULL.
    put(32'h60, 32'h61, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    check_eq("rstfull pre ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstfull in_ready", in_ready, 1);
    check_eq("rstfull out_valid", out_valid, 0);
    check_eq("rstfull Rs1", Rs1, 0);
    check_eq("rstfull Rs2", Rs2, 0);
    check_eq("rstfull funct7_5", funct7_5, 0);
    @(negedge CLK);
    rst_n = 1'b1;
    cyc();
    check_eq("rstfull stays empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
